shot_clock_timebase: RTL and testbench

- Upstream stage of the 24-second shot-clock countdown.
- Divides the board system clock into the 1 Hz square wave that clocks the countdown/7-segment stage.
- Debounces the start/pause pushbutton and runs a run/pause state machine, so the 1 Hz clock only advances while play is live.
- Shares the active-low reset key with the countdown stage, so both restart together.

---
 rtl/shot_clock_timebase.sv | 115 +++++++++++
 tb/tb_shot_clock_timebase.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/shot_clock_timebase.sv
// Front end of the shot clock: debounces the start/pause key, runs the
// IDLE/RUN/PAUSE state machine and divides the system clock down to 1 Hz.
module shot_clock_timebase #(
    parameter int CLK_HZ    = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic clock,
    input  logic key2,
    input  logic key3,
    output logic sec_clk,
    output logic sec_tick,
    output logic running,
    output logic idle
);

    localparam int HALF  = CLK_HZ / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       sync_q;
    logic             db_level;
    logic [DB_W-1:0]  db_cnt;
    logic             press;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge key2) begin
        if (!key2) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key3};
        end
    end

    // A level change is accepted only after DB_CYCLES consecutive cycles of
    // disagreement; press fires once when the accepted level falls.
    always_ff @(posedge clock or negedge key2) begin
        if (!key2) begin
            db_level <= 1'b1;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_q[1];
                db_cnt   <= '0;
                press    <= ~sync_q[1];
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge key2) begin
        if (!key2) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            idle    <= 1'b1;
        end else if (press) begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_RUN;
                    running <= 1'b1;
                    idle    <= 1'b0;
                end
                ST_RUN: begin
                    state   <= ST_PAUSE;
                    running <= 1'b0;
                    idle    <= 1'b0;
                end
                ST_PAUSE: begin
                    state   <= ST_RUN;
                    running <= 1'b1;
                    idle    <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    idle    <= 1'b1;
                end
            endcase
        end
    end

    // Counts only in RUN so a paused partial second resumes where it stopped.
    always_ff @(posedge clock or negedge key2) begin
        if (!key2) begin
            cnt      <= '0;
            sec_clk  <= 1'b1;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            if (state == ST_RUN) begin
                if (cnt == CNT_LAST) begin
                    cnt      <= '0;
                    sec_clk  <= ~sec_clk;
                    sec_tick <= ~sec_clk;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_shot_clock_timebase.sv
// Directed bench for shot_clock_timebase with CLK_HZ=20 and DB_CYCLES=4:
// start, period, pause/resume phase, coincident press, bounce and reset.
module tb_shot_clock_timebase;

    logic clock;
    logic key2;
    logic key3;
    logic sec_clk;
    logic sec_tick;
    logic running;
    logic idle;

    int errors;
    int checks;
    int tick_cnt;

    shot_clock_timebase #(
        .CLK_HZ    (20),
        .DB_CYCLES (4)
    ) dut (
        .clock    (clock),
        .key2     (key2),
        .key3     (key3),
        .sec_clk  (sec_clk),
        .sec_tick (sec_tick),
        .running  (running),
        .idle     (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sec_tick) tick_cnt = tick_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        tick_cnt = 0;
        key2     = 1'b0;
        key3     = 1'b1;
        repeat (3) step();
        check("rst_sec_clk", {31'd0, sec_clk}, 32'd1);
        check("rst_sec_tick", {31'd0, sec_tick}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        key2 = 1'b1;
        repeat (2) step();
        check("idle_after_release", {31'd0, idle}, 32'd1);

        // k counts rising edges after key3 first goes low.
        key3 = 1'b0;
        for (int k = 1; k <= 262; k++) begin
            step();
            case (k)
                6:   check("start_not_yet", {31'd0, running}, 32'd0);
                7: begin
                    check("start_running", {31'd0, running}, 32'd1);
                    check("start_idle", {31'd0, idle}, 32'd0);
                    check("start_sec_clk", {31'd0, sec_clk}, 32'd1);
                end
                16:  check("pre_fall", {31'd0, sec_clk}, 32'd1);
                17:  check("first_fall", {31'd0, sec_clk}, 32'd0);
                26: begin
                    check("pre_rise", {31'd0, sec_clk}, 32'd0);
                    check("pre_rise_tick", {31'd0, sec_tick}, 32'd0);
                end
                27: begin
                    check("first_rise", {31'd0, sec_clk}, 32'd1);
                    check("first_tick", {31'd0, sec_tick}, 32'd1);
                end
                28:  check("tick_one_cycle", {31'd0, sec_tick}, 32'd0);
                46:  check("pre_second_tick", {31'd0, sec_tick}, 32'd0);
                47: begin
                    check("second_rise", {31'd0, sec_clk}, 32'd1);
                    check("second_tick", {31'd0, sec_tick}, 32'd1);
                end
                48:  check("tick_count_run", tick_cnt, 32'd2);
                52:  check("pause_not_yet", {31'd0, running}, 32'd1);
                53: begin
                    check("pause_running", {31'd0, running}, 32'd0);
                    check("pause_idle", {31'd0, idle}, 32'd0);
                end
                60:  check("pause_frozen_a", {31'd0, sec_clk}, 32'd1);
                153: begin
                    check("pause_frozen_b", {31'd0, sec_clk}, 32'd1);
                    check("pause_no_tick", tick_cnt, 32'd2);
                end
                160: check("resume_running", {31'd0, running}, 32'd1);
                163: check("resume_pre_toggle", {31'd0, sec_clk}, 32'd1);
                164: check("resume_toggle", {31'd0, sec_clk}, 32'd0);
                173: check("coinc_pre", {31'd0, sec_clk}, 32'd0);
                174: begin
                    check("coinc_sec_clk", {31'd0, sec_clk}, 32'd1);
                    check("coinc_tick", {31'd0, sec_tick}, 32'd1);
                    check("coinc_running", {31'd0, running}, 32'd0);
                    check("coinc_idle", {31'd0, idle}, 32'd0);
                end
                200: begin
                    check("coinc_no_more", {31'd0, sec_clk}, 32'd1);
                    check("coinc_tick_count", tick_cnt, 32'd3);
                end
                210: begin
                    check("bounce_running", {31'd0, running}, 32'd0);
                    check("bounce_idle", {31'd0, idle}, 32'd0);
                end
                216: check("clean_not_yet", {31'd0, running}, 32'd0);
                217: check("clean_press", {31'd0, running}, 32'd1);
                230: begin
                    check("single_press", {31'd0, running}, 32'd1);
                    check("low_phase", {31'd0, sec_clk}, 32'd0);
                end
                262: begin
                    check("post_rst_sec_clk", {31'd0, sec_clk}, 32'd1);
                    check("post_rst_idle", {31'd0, idle}, 32'd1);
                    check("post_rst_running", {31'd0, running}, 32'd0);
                    check("post_rst_ticks", tick_cnt, 32'd3);
                end
                default: ;
            endcase

            // Drive key3/key2 for the following cycles.
            if (k == 10 || k == 56 || k == 157 || k == 177 || k == 200 || k == 220)
                key3 = 1'b1;
            if (k == 46 || k == 153 || k == 167 || k == 210)
                key3 = 1'b0;
            if (k >= 180 && k <= 199)
                key3 = (((k - 180) >> 1) & 1) != 0;
            if (k == 230) begin
                key2 = 1'b0;
                #2;
                check("async_rst_sec_clk", {31'd0, sec_clk}, 32'd1);
                check("async_rst_tick", {31'd0, sec_tick}, 32'd0);
                check("async_rst_running", {31'd0, running}, 32'd0);
                check("async_rst_idle", {31'd0, idle}, 32'd1);
            end
            if (k == 233) key2 = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
